// File: rtl/mp_pkg.sv
// rtl/mp_pkg.sv - shared precision, alignment and result types for the multi-precision path
package mp_pkg;

    typedef enum logic [1:0] {
        PREC_Q1_2  = 2'd0,
        PREC_Q1_6  = 2'd1,
        PREC_Q1_14 = 2'd2
    } prec_e;

    localparam int SHIFT_Q1_2  = 12;
    localparam int SHIFT_Q1_6  = 8;
    localparam int SHIFT_Q1_14 = 0;

    // Fixed storage width so the struct can be shared; users keep the low OUT_W bits.
    localparam int RES_DATA_W = 32;

    typedef struct packed {
        logic [RES_DATA_W-1:0] data;
        prec_e                 prec;
        logic                  sat;
    } result_t;

endpackage

// File: rtl/mp_dot_accumulator_if.sv
// rtl/mp_dot_accumulator_if.sv - result valid/ready stream of the dot-product accumulator
interface mp_dot_accumulator_if #(
    parameter int OUT_W = 18
);
    logic [OUT_W-1:0] out_data;
    logic [1:0]       out_prec;
    logic             out_sat;
    logic             out_valid;
    logic             out_ready;

    modport master (output out_data, out_prec, out_sat, out_valid, input out_ready);
    modport slave  (input out_data, out_prec, out_sat, out_valid, output out_ready);
endinterface

// File: rtl/mp_result_fifo.sv
// rtl/mp_result_fifo.sv - synchronous FIFO of result structs with push/pop/count
module mp_result_fifo
    import mp_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  result_t          push_data,
    input  logic             pop,
    output result_t          head,
    output logic [CNT_W-1:0] count
);

    result_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_en;
    logic             rd_en;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign wr_en = push && (count != CNT_W'(DEPTH));
    assign rd_en = pop && (count != '0);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mp_dot_accumulator.sv
// rtl/mp_dot_accumulator.sv - sums VEC_LEN aligned products of one precision into a saturated Q.14 result
module mp_dot_accumulator
    import mp_pkg::*;
#(
    parameter int VEC_LEN   = 8,
    parameter int OUT_W     = 18,
    parameter int OUT_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  start_prec,
    output logic        start_ready,
    input  logic [3:0]  q1_2_in,
    input  logic        q1_2_valid,
    input  logic [7:0]  q1_6_in,
    input  logic        q1_6_valid,
    input  logic [15:0] q1_14_in,
    input  logic        q1_14_valid,
    mp_dot_accumulator_if.master res,
    output logic        busy,
    output logic        stray_err,
    input  logic        err_clr
);

    localparam int ACC_W  = 16 + $clog2(VEC_LEN);
    localparam int CNT_W  = $clog2(VEC_LEN);
    localparam int CMP_W  = (ACC_W > OUT_W) ? ACC_W : OUT_W;
    localparam int FCNT_W = $clog2(OUT_DEPTH + 1);
    localparam logic [CMP_W-1:0] OUT_MAX = CMP_W'((64'd1 << OUT_W) - 64'd1);

    typedef enum logic {IDLE, ACCUM} state_e;

    state_e            state, state_next;
    prec_e             prec_q;
    logic [ACC_W-1:0]  acc, aligned, sum_next;
    logic [CMP_W-1:0]  sum_ext;
    logic [CNT_W-1:0]  cnt;
    logic [OUT_W-1:0]  res_data;
    logic              hit, start_ok, stray, push, sat;
    logic [FCNT_W-1:0] fifo_count;
    result_t           head, push_data;
    logic              unused_head_bits;

    assign start_ready = (state == IDLE) && (fifo_count < FCNT_W'(OUT_DEPTH));
    assign busy        = (state == ACCUM);

    always_comb begin
        state_next = state;
        hit        = 1'b0;
        start_ok   = 1'b0;
        stray      = 1'b0;
        push       = 1'b0;
        aligned    = '0;
        case (state)
            IDLE: begin
                start_ok = start && start_ready && (start_prec != 2'd3);
                stray    = (start && (start_prec == 2'd3)) || q1_2_valid || q1_6_valid || q1_14_valid;
                if (start_ok) state_next = ACCUM;
            end
            ACCUM: begin
                case (prec_q)
                    PREC_Q1_2: begin
                        hit     = q1_2_valid;
                        stray   = q1_6_valid || q1_14_valid;
                        aligned = ACC_W'(q1_2_in) << SHIFT_Q1_2;
                    end
                    PREC_Q1_6: begin
                        hit     = q1_6_valid;
                        stray   = q1_2_valid || q1_14_valid;
                        aligned = ACC_W'(q1_6_in) << SHIFT_Q1_6;
                    end
                    PREC_Q1_14: begin
                        hit     = q1_14_valid;
                        stray   = q1_2_valid || q1_6_valid;
                        aligned = ACC_W'(q1_14_in) << SHIFT_Q1_14;
                    end
                    default: stray = q1_2_valid || q1_6_valid || q1_14_valid;
                endcase
                if (hit && (cnt == CNT_W'(VEC_LEN - 1))) begin
                    push       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Saturation is decided on the final sum so the result lands in the FIFO on the completing edge.
    assign sum_next  = acc + aligned;
    assign sum_ext   = CMP_W'(sum_next);
    assign sat       = sum_ext > OUT_MAX;
    assign res_data  = sat ? {OUT_W{1'b1}} : OUT_W'(sum_ext);
    assign push_data = '{data: RES_DATA_W'(res_data), prec: prec_q, sat: sat};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prec_q    <= PREC_Q1_2;
            acc       <= '0;
            cnt       <= '0;
            stray_err <= 1'b0;
        end else begin
            if (start_ok) begin
                prec_q <= prec_e'(start_prec);
                acc    <= '0;
                cnt    <= '0;
            end else if (hit) begin
                acc <= sum_next;
                cnt <= cnt + 1'b1;
            end
            if (stray)        stray_err <= 1'b1;
            else if (err_clr) stray_err <= 1'b0;
        end
    end

    mp_result_fifo #(.DEPTH(OUT_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (res.out_valid && res.out_ready),
        .head      (head),
        .count     (fifo_count)
    );

    assign res.out_valid = (fifo_count != '0);
    assign res.out_data  = head.data[OUT_W-1:0];
    assign res.out_prec  = head.prec;
    assign res.out_sat   = head.sat;

    assign unused_head_bits = ^head.data[RES_DATA_W-1:OUT_W];

endmodule

// File: tb/tb_mp_dot_accumulator.sv
// tb/tb_mp_dot_accumulator.sv - directed self-checking bench for mp_dot_accumulator
module tb_mp_dot_accumulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  start_prec = 2'd0;
    logic        start_ready;
    logic [3:0]  q1_2_in = '0;
    logic        q1_2_valid = 1'b0;
    logic [7:0]  q1_6_in = '0;
    logic        q1_6_valid = 1'b0;
    logic [15:0] q1_14_in = '0;
    logic        q1_14_valid = 1'b0;
    logic        busy;
    logic        stray_err;
    logic        err_clr = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mp_dot_accumulator_if #(.OUT_W(18)) bus ();

    mp_dot_accumulator #(.VEC_LEN(8), .OUT_W(18), .OUT_DEPTH(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .start_prec  (start_prec),
        .start_ready (start_ready),
        .q1_2_in     (q1_2_in),
        .q1_2_valid  (q1_2_valid),
        .q1_6_in     (q1_6_in),
        .q1_6_valid  (q1_6_valid),
        .q1_14_in    (q1_14_in),
        .q1_14_valid (q1_14_valid),
        .res         (bus.master),
        .busy        (busy),
        .stray_err   (stray_err),
        .err_clr     (err_clr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [1:0] p);
        start      = 1'b1;
        start_prec = p;
        tick();
        start      = 1'b0;
    endtask

    task automatic feed(input logic [1:0] p, input logic [15:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            q1_2_in     = v[3:0];
            q1_6_in     = v[7:0];
            q1_14_in    = v;
            q1_2_valid  = (p == 2'd0);
            q1_6_valid  = (p == 2'd1);
            q1_14_valid = (p == 2'd2);
            tick();
        end
        q1_2_valid  = 1'b0;
        q1_6_valid  = 1'b0;
        q1_14_valid = 1'b0;
    endtask

    task automatic pop_one();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.out_ready = 1'b0;
        #12;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_out_prec", 32'(bus.out_prec), 32'd0);
        check("rst_out_sat", 32'(bus.out_sat), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_stray", 32'(stray_err), 32'd0);
        check("rst_start_ready", 32'(start_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Q1.14: eight 1.0 products
        do_start(2'd2);
        check("q14_busy", 32'(busy), 32'd1);
        check("q14_start_ready_busy", 32'(start_ready), 32'd0);
        feed(2'd2, 16'h4000, 7);
        check("q14_valid_early", 32'(bus.out_valid), 32'd0);
        feed(2'd2, 16'h4000, 1);
        check("q14_valid", 32'(bus.out_valid), 32'd1);
        check("q14_data", 32'(bus.out_data), 32'h20000);
        check("q14_prec", 32'(bus.out_prec), 32'd2);
        check("q14_sat", 32'(bus.out_sat), 32'd0);
        check("q14_idle", 32'(busy), 32'd0);
        check("q14_start_ready", 32'(start_ready), 32'd1);
        pop_one();
        check("q14_popped", 32'(bus.out_valid), 32'd0);

        // Q1.2 and Q1.6 alignment
        do_start(2'd0);
        feed(2'd0, 16'h0004, 8);
        check("q2_data", 32'(bus.out_data), 32'h20000);
        check("q2_prec", 32'(bus.out_prec), 32'd0);
        pop_one();
        do_start(2'd1);
        feed(2'd1, 16'h0040, 8);
        check("q6_data", 32'(bus.out_data), 32'h20000);
        check("q6_prec", 32'(bus.out_prec), 32'd1);
        pop_one();

        // Saturation
        do_start(2'd2);
        feed(2'd2, 16'hFFFF, 8);
        check("sat_data", 32'(bus.out_data), 32'h3FFFF);
        check("sat_flag", 32'(bus.out_sat), 32'd1);
        pop_one();

        // Backpressure fills the result FIFO
        do_start(2'd2);
        feed(2'd2, 16'h0200, 8);
        check("bp_ready_one", 32'(start_ready), 32'd1);
        do_start(2'd2);
        feed(2'd2, 16'h0400, 8);
        check("bp_ready_full", 32'(start_ready), 32'd0);
        do_start(2'd2);
        check("bp_start_ignored", 32'(busy), 32'd0);
        check("bp_head_held", 32'(bus.out_data), 32'h1000);
        pop_one();
        check("bp_second", 32'(bus.out_data), 32'h2000);
        check("bp_ready_back", 32'(start_ready), 32'd1);
        pop_one();
        check("bp_empty", 32'(bus.out_valid), 32'd0);

        // Stray products and illegal precision
        q1_6_valid = 1'b1;
        tick();
        q1_6_valid = 1'b0;
        check("stray_set", 32'(stray_err), 32'd1);
        check("stray_no_out", 32'(bus.out_valid), 32'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("stray_clr", 32'(stray_err), 32'd0);
        err_clr    = 1'b1;
        q1_2_valid = 1'b1;
        tick();
        err_clr    = 1'b0;
        q1_2_valid = 1'b0;
        check("stray_err_wins", 32'(stray_err), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        do_start(2'd3);
        check("illegal_no_accum", 32'(busy), 32'd0);
        check("illegal_stray", 32'(stray_err), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // Reset in the middle of a vector
        do_start(2'd2);
        feed(2'd2, 16'h4000, 4);
        check("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #2;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ready", 32'(start_ready), 32'd1);
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_data", 32'(bus.out_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        do_start(2'd2);
        feed(2'd2, 16'h0800, 8);
        check("post_rst_valid", 32'(bus.out_valid), 32'd1);
        check("post_rst_data", 32'(bus.out_data), 32'h4000);
        check("post_rst_sat", 32'(bus.out_sat), 32'd0);
        pop_one();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
